// File: rtl/fifo_fwft_level.sv
// First-word-fall-through FIFO with occupancy count, almost-full/empty levels,
// sticky overflow/underflow flags and synchronous flush. Any DEPTH >= 2.
module fifo_fwft_level #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             flush,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_AE    = CNT_W'(AE_LEVEL);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_nxt;
    logic [ADDR_W-1:0] wr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [WIDTH-1:0]  dout_nxt;
    logic              rd_ok;
    logic              wr_ok;

    assign full         = (count == CNT_DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    always_comb begin
        rd_ok     = read && !empty;
        wr_ok     = write && (!full || rd_ok);
        rd_nxt    = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        wr_nxt    = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        count_nxt = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        dout_nxt  = dataout;
        // Incoming word becomes head when the queue is (or is about to be) empty
        if (wr_ok && (empty || (count == CNT_W'(1) && rd_ok)))
            dout_nxt = datain;
        else if (rd_ok && count > CNT_W'(1))
            dout_nxt = mem[rd_nxt];
    end

    always_ff @(posedge ck) begin
        if (wr_ok && !flush)
            mem[wr_ptr] <= datain;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            dataout   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            dataout   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rd_ok)
                rd_ptr <= rd_nxt;
            if (wr_ok)
                wr_ptr <= wr_nxt;
            count   <= count_nxt;
            dataout <= dout_nxt;
            if (write && !wr_ok)
                overflow <= 1'b1;
            if (read && empty)
                underflow <= 1'b1;
        end
    end

endmodule
